// File: rtl/tis_ctrl_pkg.sv
// Shared types for the TIS run/step controller: FSM state encoding and default widths.
package tis_ctrl_pkg;

    localparam int DEFAULT_CYC_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_STEP    = 3'd4,
        ST_DONE    = 3'd5,
        ST_TIMEOUT = 3'd6
    } run_state_t;

    function automatic logic isCoreActive(input run_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registers a pre-synchronised button level once and emits a one-cycle pulse on its rising edge.
module edge_pulse (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= btn_i;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/tis_run_ctrl.sv
// Run/step controller for the TIS node array: gates the datapath, soft-resets it on start,
// counts enabled cycles and detects completion. Watchdog built only with TIS_RUN_CTRL_WATCHDOG_EN.
module tis_run_ctrl
    import tis_ctrl_pkg::*;
#(
    parameter int                N_OUT      = 4,
    parameter int                CYC_W      = DEFAULT_CYC_W,
    parameter logic [CYC_W-1:0]  WDOG_LIMIT = CYC_W'(1_000_000),
    parameter int                CLR_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_btn_i,
    input  logic             step_btn_i,
    input  logic             stop_btn_i,
    input  logic [N_OUT-1:0] complete_i,
    output logic             core_en_o,
    output logic             sub_rst_o,
    output logic [CYC_W-1:0] cycles_o,
    output logic [2:0]       state_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic [3:0]       clrCnt_q, clrCnt_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             startEv, stepEv, stopEv;
    logic             allComplete;
    logic             coreActive;
    logic             wdogHit;

    edge_pulse u_start (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(start_btn_i), .pulse_o(startEv));
    edge_pulse u_step  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(step_btn_i),  .pulse_o(stepEv));
    edge_pulse u_stop  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(stop_btn_i),  .pulse_o(stopEv));

    assign allComplete = &complete_i;
    assign coreActive  = isCoreActive(state_q);

`ifdef TIS_RUN_CTRL_WATCHDOG_EN
    assign wdogHit = coreActive && (cycles_q == WDOG_LIMIT - 1'b1);
`else
    logic unusedWdog;
    assign unusedWdog = ^WDOG_LIMIT;
    assign wdogHit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        cycles_d = cycles_q;

        if (coreActive && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end

        // Completion outranks the watchdog and any button event in the same cycle.
        case (state_q)
            ST_IDLE: begin
                if (startEv) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clrCnt_q == CLR_LAST) state_d = ST_RUN;
                else                      clrCnt_d = clrCnt_q + 1'b1;
            end
            ST_RUN: begin
                if (allComplete)  state_d = ST_DONE;
                else if (wdogHit) state_d = ST_TIMEOUT;
                else if (stopEv)  state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (allComplete)  state_d = ST_DONE;
                else if (startEv) state_d = ST_RUN;
                else if (stepEv)  state_d = ST_STEP;
            end
            ST_STEP: begin
                if (allComplete)  state_d = ST_DONE;
                else if (wdogHit) state_d = ST_TIMEOUT;
                else              state_d = ST_PAUSE;
            end
            ST_DONE, ST_TIMEOUT: begin
                if (startEv) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_CLEAR) clrCnt_d = '0;
        // Clearing on the transition itself so a restart from DONE shows zero at once.
        if (state_d == ST_CLEAR) cycles_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            clrCnt_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign core_en_o = coreActive;
    assign sub_rst_o = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign cycles_o  = cycles_q;
    assign state_o   = state_q;
    assign done_o    = (state_q == ST_DONE);
`ifdef TIS_RUN_CTRL_WATCHDOG_EN
    assign timeout_o = (state_q == ST_TIMEOUT);
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_tis_run_ctrl.sv
// Self-checking bench for tis_run_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_tis_run_ctrl;

    localparam int CYC_W = 24;
    localparam int LIMIT = 20;
    localparam int CLR   = 4;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_PAUSE = 3, S_STEP = 4, S_DONE = 5, S_TIMEOUT = 6;
`ifdef TIS_RUN_CTRL_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             startBtn = 1'b0;
    logic             stepBtn = 1'b0;
    logic             stopBtn = 1'b0;
    logic [3:0]       complete = 4'h0;
    logic             coreEn, subRst, done, timeout;
    logic [CYC_W-1:0] cycles;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;

    tis_run_ctrl #(
        .N_OUT(4), .CYC_W(CYC_W), .WDOG_LIMIT(24'd20), .CLR_CYCLES(CLR)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_btn_i(startBtn), .step_btn_i(stepBtn),
        .stop_btn_i(stopBtn), .complete_i(complete), .core_en_o(coreEn), .sub_rst_o(subRst),
        .cycles_o(cycles), .state_o(state), .done_o(done), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = start, 1 = step, 2 = stop; returns once the resulting state is visible
    task automatic press(input int which);
        case (which)
            0: startBtn = 1'b1;
            1: stepBtn  = 1'b1;
            default: stopBtn = 1'b1;
        endcase
        tick();
        startBtn = 1'b0;
        stepBtn  = 1'b0;
        stopBtn  = 1'b0;
        tick();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        startBtn = 1'b0; stepBtn = 1'b0; stopBtn = 1'b0;
        complete = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic startToRun();
        press(0);
        repeat (CLR) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (coreEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_en: got %b expected 0", coreEn); end
        checks++; if (subRst !== 1'b1) begin errors++; $display("[TB] FAIL reset_sub_rst: got %b expected 1", subRst); end
        checks++; if (cycles !== '0) begin errors++; $display("[TB] FAIL reset_cycles: got %0d expected 0", cycles); end
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got done=%b timeout=%b expected 0/0", done, timeout); end
        applyReset();
        repeat (3) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL idle_hold: got %0d expected 0", state); end
    endtask

    task automatic test_start_done();
        applyReset();
        press(0);
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL clear_entry: got %0d expected 1", state); end
        for (int i = 0; i < CLR; i++) begin
            checks++;
            if (subRst !== 1'b1 || coreEn !== 1'b0) begin
                errors++; $display("[TB] FAIL clear_pulse[%0d]: got sub_rst=%b core_en=%b expected 1/0", i, subRst, coreEn);
            end
            tick();
        end
        checks++; if (state !== 3'd2 || coreEn !== 1'b1 || subRst !== 1'b0) begin errors++; $display("[TB] FAIL run_entry: got state=%0d core_en=%b sub_rst=%b expected 2/1/0", state, coreEn, subRst); end
        checks++; if (cycles !== 24'd0) begin errors++; $display("[TB] FAIL run_entry_cycles: got %0d expected 0", cycles); end
        repeat (9) tick();
        complete = 4'hF;
        tick();
        checks++; if (state !== 3'd5 || done !== 1'b1) begin errors++; $display("[TB] FAIL done_entry: got state=%0d done=%b expected 5/1", state, done); end
        checks++; if (cycles !== 24'd10) begin errors++; $display("[TB] FAIL done_cycles: got %0d expected 10", cycles); end
        checks++; if (coreEn !== 1'b0 || subRst !== 1'b0) begin errors++; $display("[TB] FAIL done_outputs: got core_en=%b sub_rst=%b expected 0/0", coreEn, subRst); end
        press(1);
        press(2);
        checks++; if (state !== 3'd5 || cycles !== 24'd10) begin errors++; $display("[TB] FAIL done_frozen: got state=%0d cycles=%0d expected 5/10", state, cycles); end
        complete = 4'h0;
    endtask

    task automatic test_pause_step();
        applyReset();
        startToRun();
        repeat (3) tick();
        press(2);
        checks++; if (state !== 3'd3 || cycles !== 24'd5 || coreEn !== 1'b0) begin errors++; $display("[TB] FAIL pause_entry: got state=%0d cycles=%0d core_en=%b expected 3/5/0", state, cycles, coreEn); end
        for (int i = 0; i < 3; i++) begin
            press(1);
            checks++; if (state !== 3'd4 || coreEn !== 1'b1) begin errors++; $display("[TB] FAIL step_state[%0d]: got state=%0d core_en=%b expected 4/1", i, state, coreEn); end
            tick();
            checks++; if (state !== 3'd3 || cycles !== 24'(6 + i)) begin errors++; $display("[TB] FAIL step_back[%0d]: got state=%0d cycles=%0d expected 3/%0d", i, state, cycles, 6 + i); end
        end
        press(0);
        checks++; if (state !== 3'd2 || cycles !== 24'd8) begin errors++; $display("[TB] FAIL resume: got state=%0d cycles=%0d expected 2/8", state, cycles); end
        tick();
        checks++; if (cycles !== 24'd9) begin errors++; $display("[TB] FAIL resume_count: got %0d expected 9", cycles); end
    endtask

    task automatic test_watchdog();
        logic [2:0]       expState;
        logic [CYC_W-1:0] expLater;
        expState = WDOG_ON ? 3'd6 : 3'd2;
        expLater = WDOG_ON ? 24'd20 : 24'd24;
        applyReset();
        complete = 4'b0111;
        startToRun();
        repeat (LIMIT) tick();
        checks++; if (state !== expState || cycles !== 24'd20) begin errors++; $display("[TB] FAIL wdog_limit: got state=%0d cycles=%0d expected %0d/20", state, cycles, expState); end
        checks++; if (timeout !== WDOG_ON) begin errors++; $display("[TB] FAIL wdog_flag: got %b expected %b", timeout, WDOG_ON); end
        repeat (4) tick();
        checks++; if (cycles !== expLater) begin errors++; $display("[TB] FAIL wdog_after: got %0d expected %0d", cycles, expLater); end
        complete = 4'h0;
    endtask

    task automatic test_priority();
        applyReset();
        startToRun();
        stopBtn = 1'b1;
        tick();
        stopBtn = 1'b0;
        complete = 4'hF;
        tick();
        checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL done_over_stop: got %0d expected 5", state); end
        complete = 4'h0;
        startToRun();
        press(2);
        checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL prio_pause: got %0d expected 3", state); end
        startBtn = 1'b1;
        stepBtn  = 1'b1;
        tick();
        startBtn = 1'b0;
        stepBtn  = 1'b0;
        tick();
        checks++; if (state !== 3'd2 || coreEn !== 1'b1) begin errors++; $display("[TB] FAIL start_over_step: got state=%0d core_en=%b expected 2/1", state, coreEn); end
    endtask

    task automatic test_async_reset();
        applyReset();
        startToRun();
        repeat (7) tick();
        checks++; if (cycles !== 24'd7) begin errors++; $display("[TB] FAIL pre_reset_cycles: got %0d expected 7", cycles); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || subRst !== 1'b1 || coreEn !== 1'b0) begin errors++; $display("[TB] FAIL async_reset: got state=%0d sub_rst=%b core_en=%b expected 0/1/0", state, subRst, coreEn); end
        checks++; if (cycles !== 24'd0) begin errors++; $display("[TB] FAIL async_reset_cycles: got %0d expected 0", cycles); end
        @(negedge clk);
        rst_n = 1'b1;
        startToRun();
        complete = 4'hF;
        tick();
        complete = 4'h0;
        press(0);
        checks++; if (state !== 3'd1 || cycles !== 24'd0) begin errors++; $display("[TB] FAIL restart_from_done: got state=%0d cycles=%0d expected 1/0", state, cycles); end
    endtask

    task automatic test_random();
        int m, left, cyc, nm;
        bit s1, s2, p1, p2, t1, t2;
        bit evS, evP, evT, allC, en, hung;
        applyReset();
        m = S_IDLE; left = 0; cyc = 0;
        s1 = 0; s2 = 0; p1 = 0; p2 = 0; t1 = 0; t2 = 0;
        for (int n = 0; n < 1200; n++) begin
            if ($urandom_range(0, 5) == 0) startBtn = ~startBtn;
            if ($urandom_range(0, 5) == 0) stepBtn  = ~stepBtn;
            if ($urandom_range(0, 9) == 0) stopBtn  = ~stopBtn;
            complete = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            @(posedge clk);
            evS  = s1 && !s2;
            evP  = p1 && !p2;
            evT  = t1 && !t2;
            allC = (complete == 4'hF);
            en   = (m == S_RUN) || (m == S_STEP);
            hung = WDOG_ON && en && (cyc == LIMIT - 1);
            nm = m;
            if (m == S_IDLE) begin
                if (evS) nm = S_CLEAR;
            end else if (m == S_CLEAR) begin
                left = left - 1;
                if (left == 0) nm = S_RUN;
            end else if (m == S_RUN || m == S_PAUSE || m == S_STEP) begin
                if (allC)                     nm = S_DONE;
                else if (hung)                nm = S_TIMEOUT;
                else if (m == S_RUN && evT)   nm = S_PAUSE;
                else if (m == S_PAUSE && evS) nm = S_RUN;
                else if (m == S_PAUSE && evP) nm = S_STEP;
                else if (m == S_STEP)         nm = S_PAUSE;
            end else if (evS) begin
                nm = S_CLEAR;
            end
            if (en) cyc = cyc + 1;
            if (nm == S_CLEAR && m != S_CLEAR) begin
                left = CLR;
                cyc  = 0;
            end
            m = nm;
            s2 = s1; s1 = startBtn;
            p2 = p1; p1 = stepBtn;
            t2 = t1; t1 = stopBtn;
            #1;
            checks++; if (state !== 3'(m)) begin errors++; $display("[TB] FAIL rand_state@%0d: got %0d expected %0d", n, state, m); end
            checks++; if (cycles !== 24'(cyc)) begin errors++; $display("[TB] FAIL rand_cycles@%0d: got %0d expected %0d", n, cycles, cyc); end
            checks++;
            if (coreEn !== (m == S_RUN || m == S_STEP) || subRst !== (m == S_IDLE || m == S_CLEAR) ||
                done !== (m == S_DONE) || timeout !== (m == S_TIMEOUT)) begin
                errors++;
                $display("[TB] FAIL rand_outputs@%0d: got en=%b rst=%b done=%b to=%b for state %0d", n, coreEn, subRst, done, timeout, m);
            end
        end
        startBtn = 1'b0; stepBtn = 1'b0; stopBtn = 1'b0; complete = 4'h0;
    endtask

    initial begin
        test_reset();
        test_start_done();
        test_pause_step();
        test_watchdog();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tis_run_ctrl.md
# tis_run_ctrl

Run/step controller for the TIS node array. Sits between the board buttons and the datapath (input rows, core complex, output rows), gating the datapath with a single clock enable, issuing a soft reset on (re)start, counting executed cycles and detecting program completion from the output rows' `complete` flags. It also drives the run-status LEDs and the cycle count shown on the hex displays.

## Interface
- `N_OUT`, 4, number of output streams (width of `complete`)
- `CYC_W`, 24, cycle counter width
- `WDOG_LIMIT`, 24'd1_000_000, cycle count at which a run is declared hung
- `CLR_CYCLES`, 4, soft-reset pulse length in cycles (1..15)

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `rst`  in  1  asynchronous, active-low reset
- `start_btn`  in  1  start/resume request, level, pre-synchronised, rising-edge sensitive
- `step_btn`  in  1  single-step request, rising-edge sensitive
- `stop_btn`  in  1  pause request, rising-edge sensitive
- `complete`  in  N_OUT  per-stream completion from output rows
- `core_en`  out  1  datapath clock enable
- `sub_rst`  out  1  synchronous active-high soft reset to datapath
- `cycles`  out  CYC_W  enabled cycles since last start
- `state`  out  3  current FSM state encoding
- `done`  out  1  all streams complete
- `timeout`  out  1  watchdog fired

## Operation
- States and encodings: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, STEP=4, DONE=5, TIMEOUT=6.
- Edge detect: each button registered once; event = current & ~previous, one-cycle pulse.
- IDLE: sub_rst=1, core_en=0. start event -> CLEAR.
- CLEAR: sub_rst=1, cycles held at 0, counter of CLR_CYCLES cycles; on expiry -> RUN.
- RUN: core_en=1; cycles increments each cycle (saturates at all-ones). stop event -> PAUSE. start/step events ignored.
- PAUSE: core_en=0. step event -> STEP. start event -> RUN (no clear, cycles retained). start and step same cycle: start wins.
- STEP: core_en=1 for exactly one cycle, cycles+1, then -> PAUSE.
- Completion: in RUN, PAUSE or STEP, `&complete`=1 -> DONE next cycle; overrides stop, step and watchdog in the same cycle.
- Watchdog: in RUN or STEP, cycles == WDOG_LIMIT-1 while incrementing -> TIMEOUT.
- DONE / TIMEOUT: core_en=0, sub_rst=0 (results stay visible), cycles frozen. start event -> CLEAR. step/stop ignored.
- Outputs are Moore-decoded from registered state: core_en=(RUN|STEP), sub_rst=(IDLE|CLEAR), done=(DONE), timeout=(TIMEOUT).

## Timing
- Reset values: state IDLE, core_en 0, sub_rst 1, cycles 0, done 0, timeout 0, edge registers 0.
- Button rise at edge n -> event in cycle n+1 -> new state visible at n+2.
- start from IDLE: sub_rst high CLR_CYCLES cycles after entering CLEAR, core_en high the following cycle.
- cycles update one cycle after each core_en-high cycle; equals count of core_en-high cycles since CLEAR.
- Async reset mid-run returns to IDLE immediately; datapath held in soft reset until next start.

## Configuration
- `TIS_RUN_CTRL_WATCHDOG_EN`: defined -> watchdog active, TIMEOUT reachable. Undefined -> no compare logic, TIMEOUT unreachable, `timeout` tied 0, run continues until DONE or stop; WDOG_LIMIT ignored.

## Structure
- Package `tis_ctrl_pkg`: state enum `run_state_t` with the encodings above, default `CYC_W`.
- Sub-module `edge_pulse` (register + rising-edge detect, async active-low reset), instantiated three times.

## Test plan
- Reset, start pulse -> sub_rst high 4 cycles, then core_en high; complete=4'b1111 after 10 RUN cycles -> DONE, cycles=10, core_en=0.
- RUN, stop at cycle 5 -> PAUSE, cycles=5; three step pulses -> three single core_en cycles, cycles=8; start -> RUN resumes from 8.
- WDOG_LIMIT=20, complete stuck 4'b0111 -> TIMEOUT with cycles=20; without macro -> stays RUN, cycles passes 20.
- complete=4'b1111 and stop event same cycle -> DONE, not PAUSE; start+step same cycle in PAUSE -> RUN.
- rst low mid-RUN (cycles=7) -> IDLE immediately, sub_rst=1, cycles=0; start from DONE -> CLEAR, cycles=0.
